prio_enc_seq: RTL and testbench

PRIO_ENC_SEQ -- requirements
Module: prio_enc_seq

---
 rtl/prio_enc_seq.sv | 107 ++++++++++
 tb/tb_prio_enc_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_enc_seq.sv
// Registered priority encoder with fixed and round-robin arbitration modes.
// Single-stage valid/ready pipeline: one result per cycle, no skid buffer.
module prio_enc_seq #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         req_valid,
  output logic         req_ready,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot,
  output logic         none,
  output logic         out_valid,
  input  logic         out_ready
);

  logic         out_valid_q, out_valid_d;
  logic         none_q, none_d;
  logic [W-1:0] grant_idx_q, grant_idx_d;
  logic [N-1:0] grant_onehot_q, grant_onehot_d;
  logic [W-1:0] last_q, last_d;

  logic         accept;
  logic         any_req;
  logic [W-1:0] start_idx;
  logic [W-1:0] fixed_idx;
  logic [W-1:0] rr_idx;
  logic         rr_found;
  logic [W-1:0] sel_idx;

  // Position k steps below s, wrapping modulo N (N need not be a power of two).
  function automatic logic [W-1:0] rr_pos(input logic [W-1:0] s, input int k);
    int p;
    p = (int'(s) + N - k) % N;
    return W'(p);
  endfunction

  assign req_ready = !out_valid_q || out_ready;
  assign accept    = req_valid && req_ready;
  assign any_req   = |req;
  assign start_idx = (last_q == '0) ? W'(N - 1) : last_q - 1'b1;
  assign sel_idx   = mode ? rr_idx : fixed_idx;

  always_comb begin
    fixed_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) fixed_idx = W'(i);
    end
  end

  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!rr_found && req[rr_pos(start_idx, k)]) begin
        rr_idx   = rr_pos(start_idx, k);
        rr_found = 1'b1;
      end
    end
  end

  // Outputs hold while stalled; a drain without a new accept only drops valid.
  always_comb begin
    out_valid_d    = out_valid_q;
    none_d         = none_q;
    grant_idx_d    = grant_idx_q;
    grant_onehot_d = grant_onehot_q;
    last_d         = last_q;
    if (accept) begin
      out_valid_d    = 1'b1;
      none_d         = !any_req;
      grant_idx_d    = any_req ? sel_idx : '0;
      grant_onehot_d = '0;
      if (any_req) begin
        grant_onehot_d[sel_idx] = 1'b1;
        if (mode) last_d = sel_idx;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      none_q         <= 1'b0;
      grant_idx_q    <= '0;
      grant_onehot_q <= '0;
      last_q         <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      none_q         <= none_d;
      grant_idx_q    <= grant_idx_d;
      grant_onehot_q <= grant_onehot_d;
      last_q         <= last_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign none         = none_q;
  assign grant_idx    = grant_idx_q;
  assign grant_onehot = grant_onehot_q;

endmodule

// File: tb/tb_prio_enc_seq.sv
// Directed self-checking bench for prio_enc_seq at N=8.
module tb_prio_enc_seq;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic         mode;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] grant_idx;
  logic [N-1:0] grant_onehot;
  logic         none;
  logic         out_valid;
  logic         out_ready;

  int checks = 0;
  int errors = 0;

  prio_enc_seq #(.N(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .mode(mode),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .grant_idx(grant_idx),
    .grant_onehot(grant_onehot),
    .none(none),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req       = '0;
    mode      = 1'b0;
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req       = 8'hFF;
    mode      = 1'b0;
    out_ready = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || none !== 1'b0 || grant_idx !== 3'd0 || grant_onehot !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_outputs got v=%b n=%b idx=%0d oh=%h exp v=0 n=0 idx=0 oh=00",
               out_valid, none, grant_idx, grant_onehot);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready got %b exp 1", req_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_accept_in_reset got out_valid=%b exp 0", out_valid);
    end
    req_valid = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
  endtask

  task automatic test_fixed();
    mode      = 1'b0;
    req       = 8'h28;
    req_valid = 1'b1;
    out_ready = 1'b1;
    step();
    req_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || grant_idx !== 3'd5 || grant_onehot !== 8'h20 || none !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fixed_28 got v=%b idx=%0d oh=%h n=%b exp v=1 idx=5 oh=20 n=0",
               out_valid, grant_idx, grant_onehot, none);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || grant_idx !== 3'd5 || grant_onehot !== 8'h20) begin
      errors++;
      $display("[TB] FAIL drain_hold got v=%b idx=%0d oh=%h exp v=0 idx=5 oh=20",
               out_valid, grant_idx, grant_onehot);
    end
  endtask

  task automatic test_zero();
    mode      = 1'b1;
    req       = 8'h00;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || none !== 1'b1 || grant_idx !== 3'd0 || grant_onehot !== 8'h00) begin
      errors++;
      $display("[TB] FAIL zero_req got v=%b n=%b idx=%0d oh=%h exp v=1 n=1 idx=0 oh=00",
               out_valid, none, grant_idx, grant_onehot);
    end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] exp_seq [9] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    logic [N-1:0] exp_oh;
    do_reset();
    mode      = 1'b1;
    req       = 8'hFF;
    req_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      exp_oh = 8'h01 << exp_seq[i];
      checks++;
      if (out_valid !== 1'b1 || grant_idx !== exp_seq[i] || grant_onehot !== exp_oh || none !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rr_ff[%0d] got v=%b idx=%0d oh=%h exp v=1 idx=%0d oh=%h",
                 i, out_valid, grant_idx, grant_onehot, exp_seq[i], exp_oh);
      end
    end
    req = 8'h81;
    step();
    checks++;
    if (grant_idx !== 3'd0 || grant_onehot !== 8'h01) begin
      errors++;
      $display("[TB] FAIL rr_81_first got idx=%0d oh=%h exp idx=0 oh=01", grant_idx, grant_onehot);
    end
    step();
    checks++;
    if (grant_idx !== 3'd7 || grant_onehot !== 8'h80) begin
      errors++;
      $display("[TB] FAIL rr_81_second got idx=%0d oh=%h exp idx=7 oh=80", grant_idx, grant_onehot);
    end
    req_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    mode      = 1'b0;
    req       = 8'h28;
    req_valid = 1'b1;
    out_ready = 1'b0;
    step();
    req = 8'h03;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_ready[%0d] got %b exp 0", i, req_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || grant_idx !== 3'd5 || grant_onehot !== 8'h20 || none !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d] got v=%b idx=%0d oh=%h n=%b exp v=1 idx=5 oh=20 n=0",
                 i, out_valid, grant_idx, grant_onehot, none);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release_ready got %b exp 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || grant_idx !== 3'd1 || grant_onehot !== 8'h02) begin
      errors++;
      $display("[TB] FAIL bp_release got v=%b idx=%0d oh=%h exp v=1 idx=1 oh=02",
               out_valid, grant_idx, grant_onehot);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    mode      = 1'b1;
    req       = 8'hFF;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    req_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || grant_idx !== 3'd3) begin
      errors++;
      $display("[TB] FAIL pre_reset got v=%b idx=%0d exp v=1 idx=3", out_valid, grant_idx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || grant_idx !== 3'd0 || grant_onehot !== 8'h00) begin
      errors++;
      $display("[TB] FAIL async_reset got v=%b idx=%0d oh=%h exp v=0 idx=0 oh=00",
               out_valid, grant_idx, grant_onehot);
    end
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || grant_idx !== 3'd7 || grant_onehot !== 8'h80) begin
      errors++;
      $display("[TB] FAIL post_reset_rr got v=%b idx=%0d oh=%h exp v=1 idx=7 oh=80",
               out_valid, grant_idx, grant_onehot);
    end
  endtask

  task automatic test_mode_switch();
    logic         modes [3] = '{1'b1, 1'b0, 1'b1};
    logic [N-1:0] reqs  [3] = '{8'h10, 8'h1F, 8'hFF};
    logic [W-1:0] exps  [3] = '{3'd4, 3'd4, 3'd3};
    do_reset();
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mode = modes[i];
      req  = reqs[i];
      step();
      checks++;
      if (out_valid !== 1'b1 || grant_idx !== exps[i] || none !== 1'b0) begin
        errors++;
        $display("[TB] FAIL mode_switch[%0d] got v=%b idx=%0d exp v=1 idx=%0d",
                 i, out_valid, grant_idx, exps[i]);
      end
    end
    req_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_zero();
    test_round_robin();
    test_backpressure();
    test_reset_mid_run();
    test_mode_switch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
